ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter, the send direction of the existing ps2_keyboard receiver.
- Sends command bytes to the keyboard: 0xED LED set, 0xFF reset, 0xF4 enable.
- Drives the shared ps2_clk/ps2_data lines through open-drain enables. Reports device ACK, ACK error and timeout to the top level.
- While this block is busy, the top level holds the receiver's clrn low.

---
 rtl/ps2_host_tx_pkg.sv | 35 +++
 rtl/ps2_host_tx_sync.sv | 51 +++++
 rtl/ps2_host_tx.sv | 191 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// ----------------------------------------------------------------------------
// ps2_host_tx_pkg
// Shared definitions for the host-to-device PS/2 transmitter:
//   - ps2_state_e : transmitter FSM state encoding (3 bits)
//   - DEF_*       : default timing constants for a 50 MHz system clock
//   - CMD_*       : keyboard command codes the top level normally sends
//   - oddParity   : PS/2 parity bit for a data byte
// ----------------------------------------------------------------------------
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      REQ       = 3'd2,
      DATA      = 3'd3,
      PARITY    = 3'd4,
      ACK       = 3'd5,
      WAIT_IDLE = 3'd6
   } ps2_state_e;

   localparam int DEF_INHIBIT_CYCLES = 5000;
   localparam int DEF_TIMEOUT_CYCLES = 750000;
   localparam int DEF_SYNC_STAGES    = 2;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;

   // PS/2 uses odd parity: the parity bit makes the total count of ones
   // across the eight data bits plus parity odd.
   function automatic logic oddParity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// ----------------------------------------------------------------------------
// ps2_sync_edge
// Brings the asynchronous PS/2 clock and data lines into the system clock
// domain and flags falling edges of the synchronized clock.
// Ports:
//   clk, reset   : system clock, async active-high reset
//   clkRaw_i     : raw PS/2 clock line
//   dataRaw_i    : raw PS/2 data line
//   clkSync_o    : synchronized PS/2 clock
//   dataSync_o   : synchronized PS/2 data (same latency as clkSync_o)
//   clkFall_o    : one-cycle flag, synchronized clock went 1 -> 0
// STAGES must be at least 2.
// ----------------------------------------------------------------------------
module ps2_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clkRaw_i,
   input  logic dataRaw_i,
   output logic clkSync_o,
   output logic dataSync_o,
   output logic clkFall_o
);

   logic [STAGES-1:0] clkSh_q;
   logic [STAGES-1:0] dataSh_q;
   logic              clkPrev_q;

   // Both lines run through identical flop chains so that data sampled on a
   // detected clock edge lines up with that edge. Flops reset to 1 (idle
   // bus) so leaving reset never fabricates a falling edge on an idle bus.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clkSh_q   <= '1;
         dataSh_q  <= '1;
         clkPrev_q <= 1'b1;
      end else begin
         clkSh_q   <= (clkSh_q << 1) | STAGES'(clkRaw_i);
         dataSh_q  <= (dataSh_q << 1) | STAGES'(dataRaw_i);
         clkPrev_q <= clkSh_q[STAGES-1];
      end
   end

   // Falling edge: the previous synchronized sample was high and the
   // current one is low.
   assign clkSync_o  = clkSh_q[STAGES-1];
   assign dataSync_o = dataSh_q[STAGES-1];
   assign clkFall_o  = clkPrev_q & ~clkSh_q[STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Inhibits the bus, issues request-to-send,
// then shifts a command byte, odd parity and stop bit out on the device's
// clock, and checks the device ACK. Lines are driven open-drain via enables.
// Ports:
//   clk, reset          : system clock, async active-high reset
//   tx_data, tx_valid   : command byte offered by the caller
//   tx_ready            : idle, a byte is accepted on tx_valid & tx_ready
//   ps2_clk_i/data_i    : sampled PS/2 bus lines
//   ps2_clk_oe/data_oe  : 1 pulls the corresponding bus line low
//   busy                : transfer in progress (inverse of tx_ready)
//   done                : pulse, good ACK received and bus idle again
//   ack_err             : pulse, data line high at the ACK clock edge
//   timeout_err         : pulse, transfer aborted by the timeout
// ----------------------------------------------------------------------------
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout_err
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [INH_W-1:0] INH_LAST    = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_PRELAST = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

   ps2_state_e       state_q;
   logic [7:0]       shift_q;
   logic             parity_q;
   logic [3:0]       bitCnt_q;
   logic [INH_W-1:0] inhCnt_q;
   logic [TO_W-1:0]  toCnt_q;
   logic             ackBad_q;
   logic             clkOe_q;
   logic             dataOe_q;
   logic             done_q;
   logic             ackErr_q;
   logic             toErr_q;

   logic clkSync;
   logic dataSync;
   logic clkFall;

   // Synchronize the bus lines and find the device's falling clock edges,
   // which are the moments the host must present the next bit.
   ps2_sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk        (clk),
      .reset      (reset),
      .clkRaw_i   (ps2_clk_i),
      .dataRaw_i  (ps2_data_i),
      .clkSync_o  (clkSync),
      .dataSync_o (dataSync),
      .clkFall_o  (clkFall)
   );

   // Transmit FSM. All line enables and status pulses are registered here so
   // the async reset releases the bus immediately. The pulses default low
   // every cycle and are raised only on the transition that reports them.
   // Once the clock line has been released, every waiting state shares one
   // timeout counter, and an expiring timeout wins over a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         parity_q <= 1'b0;
         bitCnt_q <= '0;
         inhCnt_q <= '0;
         toCnt_q  <= '0;
         ackBad_q <= 1'b0;
         clkOe_q  <= 1'b0;
         dataOe_q <= 1'b0;
         done_q   <= 1'b0;
         ackErr_q <= 1'b0;
         toErr_q  <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         ackErr_q <= 1'b0;
         toErr_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (tx_valid) begin
                  shift_q  <= tx_data;
                  parity_q <= oddParity(tx_data);
                  inhCnt_q <= '0;
                  clkOe_q  <= 1'b1;
                  dataOe_q <= (INHIBIT_CYCLES == 1);
                  state_q  <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (inhCnt_q == INH_LAST) begin
                  clkOe_q  <= 1'b0;
                  dataOe_q <= 1'b1;
                  toCnt_q  <= '0;
                  state_q  <= REQ;
               end else begin
                  inhCnt_q <= inhCnt_q + 1'b1;
                  if (inhCnt_q == INH_PRELAST) begin
                     dataOe_q <= 1'b1;
                  end
               end
            end
            default: begin
               if (toCnt_q == TO_LAST) begin
                  clkOe_q  <= 1'b0;
                  dataOe_q <= 1'b0;
                  toErr_q  <= 1'b1;
                  state_q  <= IDLE;
               end else begin
                  toCnt_q <= toCnt_q + 1'b1;
                  case (state_q)
                     REQ: begin
                        if (clkFall) begin
                           dataOe_q <= ~shift_q[0];
                           shift_q  <= shift_q >> 1;
                           bitCnt_q <= 4'd1;
                           state_q  <= DATA;
                        end
                     end
                     DATA: begin
                        if (clkFall) begin
                           if (bitCnt_q == 4'd8) begin
                              dataOe_q <= ~parity_q;
                              state_q  <= PARITY;
                           end else begin
                              dataOe_q <= ~shift_q[0];
                              shift_q  <= shift_q >> 1;
                              bitCnt_q <= bitCnt_q + 4'd1;
                           end
                        end
                     end
                     PARITY: begin
                        if (clkFall) begin
                           dataOe_q <= 1'b0;
                           state_q  <= ACK;
                        end
                     end
                     ACK: begin
                        if (clkFall) begin
                           ackBad_q <= dataSync;
                           ackErr_q <= dataSync;
                           state_q  <= WAIT_IDLE;
                        end
                     end
                     WAIT_IDLE: begin
                        if (clkSync && dataSync) begin
                           done_q  <= ~ackBad_q;
                           state_q <= IDLE;
                        end
                     end
                     default: begin
                        state_q <= IDLE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

   // Status decoded straight from the registered state.
   assign tx_ready    = (state_q == IDLE);
   assign busy        = ~tx_ready;
   assign ps2_clk_oe  = clkOe_q;
   assign ps2_data_oe = dataOe_q;
   assign done        = done_q;
   assign ack_err     = ackErr_q;
   assign timeout_err = toErr_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
// Self-checking bench: a behavioural PS/2 keyboard drives the bus clock and
// acknowledges frames; every frame the device captures is compared with the
// frame a reference model builds from the byte (LSB first, odd parity, stop).
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;
   import ps2_host_tx_pkg::*;

   localparam int INH = 8;
   localparam int TO  = 2000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] txData = 8'h00;
   logic       txValid = 1'b0;
   logic       txReady, clkOe, dataOe, busy, done, ackErr, toErr;
   logic       devClkLow = 1'b0;
   logic       devDataLow = 1'b0;
   logic       clkLine, dataLine;

   int vectors = 0;
   int miscompares = 0;

   // Open-drain bus: a line is low whenever either side pulls it.
   assign clkLine  = ~(clkOe | devClkLow);
   assign dataLine = ~(dataOe | devDataLow);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO),
      .SYNC_STAGES    (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tx_data     (txData),
      .tx_valid    (txValid),
      .tx_ready    (txReady),
      .ps2_clk_i   (clkLine),
      .ps2_data_i  (dataLine),
      .ps2_clk_oe  (clkOe),
      .ps2_data_oe (dataOe),
      .busy        (busy),
      .done        (done),
      .ack_err     (ackErr),
      .timeout_err (toErr)
   );

   // Bus monitor: measures the inhibit pulse, timestamps the clock release
   // and status pulses, and tallies protocol invariant violations.
   int   cycleNo = 0, oeRun = 0, lastInhLen = 0, relCycle = 0, riseCount = 0;
   int   doneTotal = 0, ackErrTotal = 0, toTotal = 0, lastDoneCycle = 0, toCycle = 0;
   int   exclViol = 0, invViol = 0, longViol = 0;
   logic lastInhDataOe = 1'b0, toOeAny = 1'b1, prevClkOe = 1'b0;
   logic prevDone = 1'b0, prevAck = 1'b0, prevTo = 1'b0;

   always @(negedge clk) begin
      cycleNo <= cycleNo + 1;
      if (clkOe) begin
         if (!prevClkOe) riseCount <= riseCount + 1;
         oeRun         <= oeRun + 1;
         lastInhDataOe <= dataOe;
      end else if (prevClkOe) begin
         lastInhLen <= oeRun;
         oeRun      <= 0;
         relCycle   <= cycleNo;
      end
      prevClkOe <= clkOe;
      if (done) begin
         doneTotal     <= doneTotal + 1;
         lastDoneCycle <= cycleNo;
      end
      if (ackErr) ackErrTotal <= ackErrTotal + 1;
      if (toErr) begin
         toTotal <= toTotal + 1;
         toCycle <= cycleNo;
         toOeAny <= clkOe | dataOe;
      end
      if ((int'(done) + int'(ackErr) + int'(toErr)) > 1) exclViol <= exclViol + 1;
      if ((done && prevDone) || (ackErr && prevAck) || (toErr && prevTo)) longViol <= longViol + 1;
      if ((txReady && (clkOe || dataOe)) || (busy !== ~txReady)) invViol <= invViol + 1;
      prevDone <= done;
      prevAck  <= ackErr;
      prevTo   <= toErr;
   end

   // Reference model: the frame a device should see for a byte, bit k being
   // the k-th bit it clocks in: eight data bits LSB first, odd parity, stop.
   function automatic logic [9:0] refFrame(input logic [7:0] b);
      logic par;
      par = (($countones(b) % 2) == 0);
      return {1'b1, par, b};
   endfunction

   // Behavioural keyboard: waits for inhibit + release, then produces clock
   // pulses with a 20-cycle period, capturing the data line at each rising
   // edge. stopAfter > 0 abandons the frame with the clock held low shortly
   // after that many falling edges.
   task automatic deviceFrame(input bit ackGood, input int stopAfter,
                              output logic [9:0] bits, output bit ok);
      int n;
      ok   = 1'b1;
      bits = '0;
      n = 0;
      while (!clkOe && n < 50) begin @(negedge clk); n++; end
      if (!clkOe) begin ok = 1'b0; return; end
      n = 0;
      while (clkOe && n < 100) begin @(negedge clk); n++; end
      if (clkOe) begin ok = 1'b0; return; end
      repeat (10) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         devClkLow = 1'b1;
         if (stopAfter == k + 1) begin
            repeat (6) @(negedge clk);
            return;
         end
         repeat (10) @(negedge clk);
         bits[k]   = dataLine;
         devClkLow = 1'b0;
         repeat (10) @(negedge clk);
      end
      devDataLow = ackGood;
      repeat (5) @(negedge clk);
      devClkLow = 1'b1;
      repeat (10) @(negedge clk);
      devClkLow = 1'b0;
      repeat (3) @(negedge clk);
      devDataLow = 1'b0;
   endtask

   // Full transfer of one byte with the device answering good or bad ACK.
   task automatic runXfer(input logic [7:0] b, input bit ackGood, input string name);
      int         d0, a0, n;
      logic [9:0] bits;
      bit         ok;
      d0 = doneTotal;
      a0 = ackErrTotal;
      @(negedge clk);
      txData  = b;
      txValid = 1'b1;
      n = 0;
      while (txReady && n < 20) begin @(negedge clk); n++; end
      txValid = 1'b0;
      deviceFrame(ackGood, 0, bits, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("[TB] FAIL %s handshake: inhibit/release not seen for byte %h", name, b);
      end
      vectors++;
      if (bits !== refFrame(b)) begin
         miscompares++;
         $display("[TB] FAIL %s frame: got %b expected %b (byte %h)", name, bits, refFrame(b), b);
      end
      vectors++;
      if (lastInhLen !== INH) begin
         miscompares++;
         $display("[TB] FAIL %s inhibit_len: got %0d expected %0d", name, lastInhLen, INH);
      end
      vectors++;
      if (lastInhDataOe !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL %s start_bit: data_oe in last inhibit cycle got %b expected 1", name, lastInhDataOe);
      end
      n = 0;
      while (doneTotal == d0 && ackErrTotal == a0 && n < 100) begin @(negedge clk); n++; end
      repeat (10) @(negedge clk);
      vectors++;
      if (doneTotal - d0 !== (ackGood ? 1 : 0)) begin
         miscompares++;
         $display("[TB] FAIL %s done_count: got %0d expected %0d", name, doneTotal - d0, ackGood ? 1 : 0);
      end
      vectors++;
      if (ackErrTotal - a0 !== (ackGood ? 0 : 1)) begin
         miscompares++;
         $display("[TB] FAIL %s ack_err_count: got %0d expected %0d", name, ackErrTotal - a0, ackGood ? 0 : 1);
      end
      vectors++;
      if (txReady !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL %s tx_ready_after: got %b expected 1", name, txReady);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({txReady, busy} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL reset_ready_busy: got %b expected 10", {txReady, busy});
      end
      vectors++;
      if ({clkOe, dataOe} !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL reset_oe: got %b expected 00", {clkOe, dataOe});
      end
      vectors++;
      if ({done, ackErr, toErr} !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL reset_pulses: got %b expected 000", {done, ackErr, toErr});
      end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      vectors++;
      if ({txReady, clkOe, dataOe} !== 3'b100) begin
         miscompares++;
         $display("[TB] FAIL post_reset_idle: got %b expected 100", {txReady, clkOe, dataOe});
      end
   endtask

   task automatic test_commands();
      logic [7:0] r;
      runXfer(CMD_SET_LED, 1'b1, "cmd_ED");
      runXfer(8'h01, 1'b1, "byte_01");
      runXfer(CMD_RESET, 1'b1, "cmd_FF");
      runXfer(8'h00, 1'b1, "byte_00");
      for (int i = 0; i < 4; i++) begin
         r = 8'($urandom);
         runXfer(r, 1'b1, "random");
      end
   endtask

   task automatic test_ack_error();
      logic [7:0] r;
      r = 8'($urandom);
      runXfer(r, 1'b0, "ack_err");
   endtask

   task automatic test_timeout();
      int d0, t0, n;
      d0 = doneTotal;
      t0 = toTotal;
      @(negedge clk);
      txData  = 8'($urandom);
      txValid = 1'b1;
      n = 0;
      while (txReady && n < 20) begin @(negedge clk); n++; end
      txValid = 1'b0;
      n = 0;
      while (toTotal == t0 && n < TO + 200) begin @(negedge clk); n++; end
      vectors++;
      if (toTotal - t0 !== 1) begin
         miscompares++;
         $display("[TB] FAIL timeout_seen: got %0d pulses expected 1", toTotal - t0);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (toCycle - relCycle !== TO) begin
         miscompares++;
         $display("[TB] FAIL timeout_delay: got %0d cycles expected %0d", toCycle - relCycle, TO);
      end
      vectors++;
      if (toOeAny !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL timeout_oe: got %b expected 0", toOeAny);
      end
      vectors++;
      if ({txReady, doneTotal - d0} !== {1'b1, 32'd0}) begin
         miscompares++;
         $display("[TB] FAIL timeout_idle: tx_ready %b done %0d expected 1 and 0", txReady, doneTotal - d0);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      logic [9:0] bits;
      bit         ok;
      int         n;
      b = 8'($urandom) & 8'hF7;
      @(negedge clk);
      txData  = b;
      txValid = 1'b1;
      n = 0;
      while (txReady && n < 20) begin @(negedge clk); n++; end
      txValid = 1'b0;
      deviceFrame(1'b1, 4, bits, ok);
      vectors++;
      if ({ok, dataOe} !== 2'b11) begin
         miscompares++;
         $display("[TB] FAIL mid_bit3: ok/data_oe got %b expected 11", {ok, dataOe});
      end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if ({clkOe, dataOe, txReady} !== 3'b001) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_release: clk_oe/data_oe/tx_ready got %b expected 001", {clkOe, dataOe, txReady});
      end
      repeat (3) @(negedge clk);
      reset      = 1'b0;
      devClkLow  = 1'b0;
      devDataLow = 1'b0;
      repeat (10) @(negedge clk);
      runXfer(CMD_ENABLE, 1'b1, "after_reset_F4");
   endtask

   task automatic test_back_to_back();
      logic [9:0] bits1, bits2;
      bit         ok1, ok2;
      int         d0, r0, n;
      d0 = doneTotal;
      r0 = riseCount;
      @(negedge clk);
      txData  = CMD_SET_LED;
      txValid = 1'b1;
      n = 0;
      while (txReady && n < 20) begin @(negedge clk); n++; end
      txData = CMD_ENABLE;
      deviceFrame(1'b1, 0, bits1, ok1);
      n = 0;
      while (doneTotal == d0 && n < 100) begin @(negedge clk); n++; end
      vectors++;
      if ({ok1, bits1} !== {1'b1, refFrame(CMD_SET_LED)}) begin
         miscompares++;
         $display("[TB] FAIL b2b_first: got %b expected %b", {ok1, bits1}, {1'b1, refFrame(CMD_SET_LED)});
      end
      vectors++;
      if ({doneTotal - d0, riseCount - r0} !== {32'd1, 32'd1}) begin
         miscompares++;
         $display("[TB] FAIL b2b_hold: done %0d inhibits %0d expected 1 and 1", doneTotal - d0, riseCount - r0);
      end
      n = 0;
      while (!clkOe && n < 20) begin @(negedge clk); n++; end
      txValid = 1'b0;
      deviceFrame(1'b1, 0, bits2, ok2);
      n = 0;
      while (doneTotal - d0 < 2 && n < 100) begin @(negedge clk); n++; end
      repeat (10) @(negedge clk);
      vectors++;
      if ({ok2, bits2} !== {1'b1, refFrame(CMD_ENABLE)}) begin
         miscompares++;
         $display("[TB] FAIL b2b_second: got %b expected %b", {ok2, bits2}, {1'b1, refFrame(CMD_ENABLE)});
      end
      vectors++;
      if ({doneTotal - d0, riseCount - r0, txReady} !== {32'd2, 32'd2, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL b2b_total: done %0d inhibits %0d tx_ready %b expected 2 2 1", doneTotal - d0, riseCount - r0, txReady);
      end
   endtask

   task automatic test_invariants();
      vectors++;
      if ({exclViol, longViol, invViol} !== {32'd0, 32'd0, 32'd0}) begin
         miscompares++;
         $display("[TB] FAIL invariants: exclusive %0d long %0d idle_oe/busy %0d expected all 0", exclViol, longViol, invViol);
      end
   endtask

   initial begin
      test_reset();
      test_commands();
      test_ack_error();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_invariants();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
